// File: rtl/spi_cmd_decoder.sv
// SPI command decoder: command byte, LSB-first payload, then a 0x00 kick commits the staged
// word to one oscillator register. Optional frame timeout when CMD_TIMEOUT_EN is defined.
module spi_cmd_decoder #(
    parameter int FREQ_W         = 24,
    parameter int PHASE_W        = 16,
    parameter int AMP_W          = 16,
    parameter int TIMEOUT_CYCLES = 250000
) (
    input  logic               i_clk50mhz,
    input  logic               i_rst_n,
    input  logic [7:0]         i_rx_byte,
    input  logic               i_rx_valid,
    output logic [2:0]         o_osc1_wave,
    output logic [FREQ_W-1:0]  o_osc1_freq,
    output logic [PHASE_W-1:0] o_osc1_phase,
    output logic [AMP_W-1:0]   o_osc1_amp,
    output logic [2:0]         o_osc2_wave,
    output logic [FREQ_W-1:0]  o_osc2_freq,
    output logic [PHASE_W-1:0] o_osc2_phase,
    output logic [AMP_W-1:0]   o_osc2_amp,
    output logic [1:0]         o_update,
    output logic               o_err,
    output logic               o_busy
);

    typedef enum logic [1:0] {ST_IDLE, ST_PAYLOAD, ST_KICK} state_t;

    localparam logic [1:0] K_WAVE  = 2'd0;
    localparam logic [1:0] K_FREQ  = 2'd1;
    localparam logic [1:0] K_PHASE = 2'd2;

    // Payload length of a command byte; zero means "not a command".
    function automatic logic [1:0] cmd_len(input logic [7:0] b);
        if (b[7:5] != 3'b000 || b[3])
            return 2'd0;
        case (b[2:0])
            3'd1:       return 2'd1;
            3'd2:       return 2'd3;
            3'd3, 3'd4: return 2'd2;
            default:    return 2'd0;
        endcase
    endfunction

    state_t             state_q;
    logic               osc_sel_q;
    logic [1:0]         kind_q;
    logic [1:0]         len_q;
    logic [1:0]         byte_cnt_q;
    logic [23:0]        staging_q;
    logic [1:0]         update_q;
    logic               err_q;
    logic [2:0]         wave_q  [2];
    logic [FREQ_W-1:0]  freq_q  [2];
    logic [PHASE_W-1:0] phase_q [2];
    logic [AMP_W-1:0]   amp_q   [2];
    logic [1:0]         new_len;

    assign new_len = cmd_len(i_rx_byte);

`ifdef CMD_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    logic [TO_W-1:0] to_cnt_q;
`endif

    always_ff @(posedge i_clk50mhz or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            osc_sel_q  <= 1'b0;
            kind_q     <= K_WAVE;
            len_q      <= 2'd0;
            byte_cnt_q <= 2'd0;
            staging_q  <= '0;
            update_q   <= 2'b00;
            err_q      <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                wave_q[i]  <= '0;
                freq_q[i]  <= '0;
                phase_q[i] <= '0;
                amp_q[i]   <= '0;
            end
`ifdef CMD_TIMEOUT_EN
            to_cnt_q <= '0;
`endif
        end else begin
            update_q <= 2'b00;
            err_q    <= 1'b0;
`ifdef CMD_TIMEOUT_EN
            if (state_q == ST_IDLE || i_rx_valid)
                to_cnt_q <= '0;
            else
                to_cnt_q <= to_cnt_q + 1'b1;
`endif
            if (i_rx_valid) begin
                case (state_q)
                    ST_PAYLOAD: begin
                        case (byte_cnt_q)
                            2'd0:    staging_q[7:0]   <= i_rx_byte;
                            2'd1:    staging_q[15:8]  <= i_rx_byte;
                            default: staging_q[23:16] <= i_rx_byte;
                        endcase
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        if (byte_cnt_q == len_q - 2'd1)
                            state_q <= ST_KICK;
                    end
                    default: begin
                        if (i_rx_byte == 8'h00) begin
                            if (state_q == ST_KICK) begin
                                case (kind_q)
                                    K_WAVE:  wave_q[osc_sel_q]  <= staging_q[2:0];
                                    K_FREQ:  freq_q[osc_sel_q]  <= staging_q[FREQ_W-1:0];
                                    K_PHASE: phase_q[osc_sel_q] <= staging_q[PHASE_W-1:0];
                                    default: amp_q[osc_sel_q]   <= staging_q[AMP_W-1:0];
                                endcase
                                update_q <= osc_sel_q ? 2'b10 : 2'b01;
                            end
                            state_q <= ST_IDLE;
                        end else begin
                            // A nonzero byte where a kick was due breaks the frame,
                            // but is still decoded as a fresh command.
                            if (state_q == ST_KICK || new_len == 2'd0)
                                err_q <= 1'b1;
                            staging_q <= '0;
                            if (new_len != 2'd0) begin
                                osc_sel_q  <= i_rx_byte[4];
                                kind_q     <= 2'(i_rx_byte[2:0] - 3'd1);
                                len_q      <= new_len;
                                byte_cnt_q <= 2'd0;
                                state_q    <= ST_PAYLOAD;
                            end else begin
                                state_q <= ST_IDLE;
                            end
                        end
                    end
                endcase
            end
`ifdef CMD_TIMEOUT_EN
            else if (state_q != ST_IDLE && to_cnt_q == TO_LAST) begin
                staging_q <= '0;
                err_q     <= 1'b1;
                state_q   <= ST_IDLE;
            end
`endif
        end
    end

    assign o_osc1_wave  = wave_q[0];
    assign o_osc1_freq  = freq_q[0];
    assign o_osc1_phase = phase_q[0];
    assign o_osc1_amp   = amp_q[0];
    assign o_osc2_wave  = wave_q[1];
    assign o_osc2_freq  = freq_q[1];
    assign o_osc2_phase = phase_q[1];
    assign o_osc2_amp   = amp_q[1];
    assign o_update     = update_q;
    assign o_err        = err_q;
    assign o_busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Bench for spi_cmd_decoder: directed frames plus random frames against a frame-level model.
module tb_spi_cmd_decoder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_byte = 8'h00;
    logic        rx_valid = 1'b0;
    logic [2:0]  osc1_wave, osc2_wave;
    logic [23:0] osc1_freq, osc2_freq;
    logic [15:0] osc1_phase, osc2_phase, osc1_amp, osc2_amp;
    logic [1:0]  update;
    logic        err, busy;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    spi_cmd_decoder #(.TIMEOUT_CYCLES(100)) dut (
        .i_clk50mhz(clk), .i_rst_n(rst_n), .i_rx_byte(rx_byte), .i_rx_valid(rx_valid),
        .o_osc1_wave(osc1_wave), .o_osc1_freq(osc1_freq), .o_osc1_phase(osc1_phase),
        .o_osc1_amp(osc1_amp), .o_osc2_wave(osc2_wave), .o_osc2_freq(osc2_freq),
        .o_osc2_phase(osc2_phase), .o_osc2_amp(osc2_amp), .o_update(update),
        .o_err(err), .o_busy(busy));

    // Frame-level model: pending command (-1 = none) and the payload bytes collected so far.
    int          m_cmd;
    int          m_pl[$];
    int          m_wave[2], m_freq[2], m_phase[2], m_amp[2];
    int          e_upd, e_err;

    function automatic int plen(input int b);
        if (b == 8'h01 || b == 8'h11) return 1;
        if (b == 8'h02 || b == 8'h12) return 3;
        if (b == 8'h03 || b == 8'h13 || b == 8'h04 || b == 8'h14) return 2;
        return 0;
    endfunction

    task automatic model_reset();
        m_cmd = -1;
        m_pl.delete();
        e_upd = 0;
        e_err = 0;
        for (int i = 0; i < 2; i++) begin
            m_wave[i] = 0; m_freq[i] = 0; m_phase[i] = 0; m_amp[i] = 0;
        end
    endtask

    task automatic model_byte(input int b);
        int val, osc;
        e_upd = 0;
        e_err = 0;
        if (m_cmd >= 0 && m_pl.size() < plen(m_cmd)) begin
            m_pl.push_back(b);
            return;
        end
        if (m_cmd >= 0) begin
            if (b == 0) begin
                val = 0;
                foreach (m_pl[i]) val += m_pl[i] * (1 << (8 * i));
                osc = m_cmd / 16;
                case (m_cmd % 16)
                    1: m_wave[osc]  = val % 8;
                    2: m_freq[osc]  = val;
                    3: m_phase[osc] = val;
                    default: m_amp[osc] = val;
                endcase
                e_upd = osc + 1;
                m_cmd = -1;
                return;
            end
            e_err = 1;
            m_cmd = -1;
        end
        if (b == 0) return;
        if (plen(b) == 0) begin
            e_err = 1;
            return;
        end
        m_cmd = b;
        m_pl.delete();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".update"}, 32'(update), 32'(e_upd));
        chk({tag, ".err"}, 32'(err), 32'(e_err));
        chk({tag, ".busy"}, 32'(busy), (m_cmd >= 0) ? 32'd1 : 32'd0);
        chk({tag, ".w1"}, 32'(osc1_wave), 32'(m_wave[0]));
        chk({tag, ".f1"}, 32'(osc1_freq), 32'(m_freq[0]));
        chk({tag, ".p1"}, 32'(osc1_phase), 32'(m_phase[0]));
        chk({tag, ".a1"}, 32'(osc1_amp), 32'(m_amp[0]));
        chk({tag, ".w2"}, 32'(osc2_wave), 32'(m_wave[1]));
        chk({tag, ".f2"}, 32'(osc2_freq), 32'(m_freq[1]));
        chk({tag, ".p2"}, 32'(osc2_phase), 32'(m_phase[1]));
        chk({tag, ".a2"}, 32'(osc2_amp), 32'(m_amp[1]));
    endtask

    // Drive one strobe at a falling edge; outputs are checked at the next falling edge.
    task automatic send(input string tag, input int b);
        rx_byte  = 8'(b);
        rx_valid = 1'b1;
        model_byte(b);
        @(negedge clk);
        rx_valid = 1'b0;
        check_all($sformatf("%s[%02h]", tag, b));
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            e_upd = 0;
            e_err = 0;
            check_all(tag);
        end
    endtask

    task automatic send_list(input string tag, input int bytes[$]);
        foreach (bytes[i]) send(tag, bytes[i]);
    endtask

    initial begin
        int cmds[8] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h11, 8'h12, 8'h13, 8'h14};
        int c, r;

        model_reset();
        repeat (2) @(negedge clk);
        check_all("reset");
        rst_n = 1'b1;
        idle("post_reset", 1);

        send_list("t1", '{8'h00, 8'h01, 8'h05, 8'h00});
        chk("t1.wave5", 32'(osc1_wave), 32'd5);
        chk("t1.upd", 32'(update), 32'd1);
        idle("t1.after", 1);

        send_list("t2", '{8'h02, 8'hFF, 8'hFF, 8'h00, 8'h00});
        chk("t2.freq", 32'(osc1_freq), 32'h00FFFF);

        send_list("t3", '{8'h14, 8'h34, 8'h12, 8'h00});
        chk("t3.amp2", 32'(osc2_amp), 32'h1234);
        chk("t3.upd", 32'(update), 32'd2);

        send_list("t4", '{8'h04, 8'hAA, 8'hBB, 8'h03});
        chk("t4.err", 32'(err), 32'd1);
        send_list("t4b", '{8'h77, 8'h66, 8'h00});
        chk("t4.phase", 32'(osc1_phase), 32'h6677);
        chk("t4.amp1", 32'(osc1_amp), 32'h0);

        send_list("t5", '{8'h7F, 8'h00});
        send_list("t5w", '{8'h01, 8'hFE});
        chk("t5.busy", 32'(busy), 32'd1);
        send("t5w", 8'h00);
        chk("t5.wave6", 32'(osc1_wave), 32'd6);

        send_list("t5r", '{8'h02, 8'h11});
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        check_all("t5.async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        send_list("t5n", '{8'h13, 8'h21, 8'h43, 8'h00});
        chk("t5.phase2", 32'(osc2_phase), 32'h4321);

`ifdef CMD_TIMEOUT_EN
        send_list("t6", '{8'h02, 8'h11});
        idle("t6.wait", 99);
        @(negedge clk);
        e_upd = 0;
        e_err = 1;
        m_cmd = -1;
        check_all("t6.timeout");
        idle("t6.quiet", 2);
        send_list("t6b", '{8'h02, 8'h11});
        idle("t6b.wait", 99);
        send_list("t6b", '{8'h22, 8'h33, 8'h00});
        chk("t6.freq", 32'(osc1_freq), 32'h332211);
`endif

        for (int f = 0; f < 60; f++) begin
            r = $urandom_range(0, 9);
            if (r == 0) begin
                send("rnd_junk", 8'h80 | $urandom_range(1, 127));
            end else begin
                c = cmds[$urandom_range(0, 7)];
                send("rnd_cmd", c);
                for (int i = 0; i < plen(c); i++)
                    send("rnd_pl", ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 255));
                if ($urandom_range(0, 6) == 0)
                    send("rnd_kick", $urandom_range(1, 255));
                else
                    send("rnd_kick", 0);
            end
            idle("rnd_gap", $urandom_range(0, 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
